// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the inst_memory word and hands it to decode
// over valid/ready, with redirect/flush and a sticky fault. Optional counters: FETCH_PERF_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_Addr,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Highest address at which a full word still fits inside the memory.
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  logic        w_target_bad;
  logic        w_pc_oob;
  logic        w_slot_free;
  logic        w_load;
  logic        w_flush;
  logic        w_pc_redirect;
  logic        w_fault_set;
  logic [31:0] w_fault_addr;

  assign w_target_bad = (redirect_target[1:0] != 2'b00) || (redirect_target > LAST_ADDR);
  assign w_pc_oob     = (r_pc > LAST_ADDR);
  assign w_slot_free  = !r_if_valid || if_ready;

  // NOTE: async active-low reset in the sensitivity list; state updates use <= only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN: begin
        if (redirect_valid) begin
          if (w_target_bad) w_state_nxt = S_FAULT;
        end else if (w_slot_free && w_pc_oob) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load        = 1'b0;
    w_flush       = 1'b0;
    w_pc_redirect = 1'b0;
    w_fault_set   = 1'b0;
    w_fault_addr  = r_pc;
    case (r_state)
      S_RUN: begin
        if (redirect_valid) begin
          // A redirect always flushes, even if decode takes the entry on this edge.
          w_flush = 1'b1;
          if (w_target_bad) begin
            w_fault_set  = 1'b1;
            w_fault_addr = redirect_target;
          end else begin
            w_pc_redirect = 1'b1;
          end
        end else if (w_slot_free) begin
          if (w_pc_oob) begin
            w_fault_set = 1'b1;
            w_flush     = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      // Fetching has stopped; only let decode drain the entry still held.
      S_FAULT: w_flush = r_if_valid && if_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
    end else begin
      if (w_pc_redirect)  r_pc <= redirect_target;
      else if (w_load)    r_pc <= r_pc + 32'd4;

      if (w_flush)        r_if_valid <= 1'b0;
      else if (w_load)    r_if_valid <= 1'b1;

      if (w_load) begin
        r_if_instr    <= instruction;
        r_if_pc       <= r_pc;
        r_if_pc_plus4 <= r_pc + 32'd4;
      end

      if (w_fault_set) begin
        r_fault    <= 1'b1;
        r_fault_pc <= w_fault_addr;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_load) r_fetch_count <= r_fetch_count + 32'd1;
      if (r_state == S_RUN && r_if_valid && !if_ready) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

  assign inst_Addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus randomized traffic checked against
// a transaction-level model of the fetch stage and a small instruction memory.
module tb_pc_fetch_unit;

  localparam int unsigned IMEM_BYTES = 32;
  localparam logic [31:0] LAST_ADDR  = 32'(IMEM_BYTES - 4);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst_Addr;
  logic [31:0] instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] mem [8];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  assign instruction = (inst_Addr <= LAST_ADDR) ? mem[inst_Addr[4:2]] : 32'hBAD0_BAD0;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_Addr       (inst_Addr),
    .instruction     (instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .fault           (fault),
    .fault_pc        (fault_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
`endif
  );

  // Reference model: architectural view of the stage after each rising edge.
  bit          m_live;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_fault_pc;
  bit          m_valid, m_fault;
  logic [31:0] m_fetch, m_stall;

  task automatic model_reset();
    m_live = 0; m_pc = 32'h0; m_valid = 0; m_instr = '0; m_ifpc = '0; m_ifpc4 = '0;
    m_fault = 0; m_fault_pc = '0; m_fetch = '0; m_stall = '0;
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rt, input bit rdy);
    if (!m_live) begin
      m_live = 1;
    end else if (m_fault) begin
      if (m_valid && rdy) m_valid = 0;
    end else begin
      if (m_valid && !rdy) m_stall = m_stall + 1;
      if (rv) begin
        m_valid = 0;
        if ((rt % 4) != 0 || rt > LAST_ADDR) begin
          m_fault = 1; m_fault_pc = rt;
        end else begin
          m_pc = rt;
        end
      end else if (!m_valid || rdy) begin
        if (m_pc > LAST_ADDR) begin
          m_fault = 1; m_fault_pc = m_pc; m_valid = 0;
        end else begin
          m_instr = mem[m_pc / 4]; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
          m_valid = 1; m_pc = m_pc + 4; m_fetch = m_fetch + 1;
        end
      end
    end
  endtask

  // Drive inputs on the falling edge, then sample 1ns after the rising edge.
  task automatic tick(input bit rv, input logic [31:0] rt, input bit rdy);
    @(negedge clk);
    redirect_valid = rv; redirect_target = rt; if_ready = rdy;
    model_step(rv, rt, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    reset = 1'b0; redirect_valid = 1'b0; redirect_target = '0; if_ready = rdy;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic load_fixed_mem();
    mem[0] = 32'h0094_0333; mem[1] = 32'h4139_03b3; mem[2] = 32'h0000_0013; mem[3] = 32'h0020_8093;
    mem[4] = 32'h0041_0113; mem[5] = 32'h0061_8193; mem[6] = 32'h0082_0213; mem[7] = 32'h00a2_8293;
  endtask

  task automatic test_reset();
    load_fixed_mem();
    reset = 1'b0;
    #2;
    total_cnt++;
    if ({if_valid, if_instr, if_pc, if_pc_plus4, fault, fault_pc, inst_Addr} !== '0)
      $display("FAIL reset_state: valid=%b instr=%h pc=%h pc4=%h fault=%b fpc=%h addr=%h, want all 0",
               if_valid, if_instr, if_pc, if_pc_plus4, fault, fault_pc, inst_Addr);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    do_reset(1'b1);
    tick(0, 0, 1);
    total_cnt++;
    if (if_valid !== 1'b0) $display("FAIL seq_edge1_valid: got %b want 0", if_valid);
    else pass_cnt++;
    tick(0, 0, 1);
    total_cnt++;
    if ({if_valid, if_instr, if_pc, if_pc_plus4} !== {1'b1, 32'h0094_0333, 32'h0, 32'h4})
      $display("FAIL seq_edge2: valid=%b instr=%h pc=%h pc4=%h want 1/00940333/0/4",
               if_valid, if_instr, if_pc, if_pc_plus4);
    else pass_cnt++;
    tick(0, 0, 1);
    total_cnt++;
    if ({if_valid, if_instr, if_pc, if_pc_plus4} !== {1'b1, 32'h4139_03b3, 32'h4, 32'h8})
      $display("FAIL seq_edge3: valid=%b instr=%h pc=%h pc4=%h want 1/413903b3/4/8",
               if_valid, if_instr, if_pc, if_pc_plus4);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      total_cnt++;
      if ({if_valid, if_instr, if_pc, inst_Addr} !== {1'b1, 32'h4139_03b3, 32'h4, 32'h8})
        $display("FAIL stall_hold_%0d: valid=%b instr=%h pc=%h addr=%h want 1/413903b3/4/8",
                 i, if_valid, if_instr, if_pc, inst_Addr);
      else pass_cnt++;
    end
    tick(0, 0, 1);
    total_cnt++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'h0000_0013, 32'h8})
      $display("FAIL stall_release: valid=%b instr=%h pc=%h want 1/00000013/8", if_valid, if_instr, if_pc);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    tick(1, 32'h10, 1);
    total_cnt++;
    if ({if_valid, inst_Addr} !== {1'b0, 32'h10})
      $display("FAIL redirect_flush: valid=%b addr=%h want 0/10", if_valid, inst_Addr);
    else pass_cnt++;
    tick(0, 0, 1);
    total_cnt++;
    if ({if_valid, if_instr, if_pc, if_pc_plus4} !== {1'b1, 32'h0041_0113, 32'h10, 32'h14})
      $display("FAIL redirect_fetch: valid=%b instr=%h pc=%h pc4=%h want 1/00410113/10/14",
               if_valid, if_instr, if_pc, if_pc_plus4);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    tick(1, 32'h0E, 1);
    total_cnt++;
    if ({fault, fault_pc, if_valid, inst_Addr} !== {1'b1, 32'h0E, 1'b0, 32'h14})
      $display("FAIL misalign_fault: fault=%b fpc=%h valid=%b addr=%h want 1/0e/0/14",
               fault, fault_pc, if_valid, inst_Addr);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick(1, 32'h4, 1'($urandom_range(0, 1)));
      total_cnt++;
      if ({fault, fault_pc, if_valid, inst_Addr} !== {1'b1, 32'h0E, 1'b0, 32'h14})
        $display("FAIL misalign_sticky_%0d: fault=%b fpc=%h valid=%b addr=%h want 1/0e/0/14",
                 i, fault, fault_pc, if_valid, inst_Addr);
      else pass_cnt++;
    end
  endtask

  task automatic test_range();
    bit seen = 0;
    do_reset(1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(0, 0, 1);
      if (if_valid && if_pc == 32'h1C) seen = 1;
    end
    total_cnt++;
    if (!seen) $display("FAIL range_reach_1c: got if_pc=%h want 0000001c within 20 cycles", if_pc);
    else pass_cnt++;
    tick(0, 0, 1);
    total_cnt++;
    if ({fault, fault_pc, if_valid} !== {1'b1, 32'h20, 1'b0})
      $display("FAIL range_fault: fault=%b fpc=%h valid=%b want 1/20/0", fault, fault_pc, if_valid);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1);
      total_cnt++;
      if ({fault, if_valid, inst_Addr} !== {1'b1, 1'b0, 32'h20})
        $display("FAIL range_frozen_%0d: fault=%b valid=%b addr=%h want 1/0/20", i, fault, if_valid, inst_Addr);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    total_cnt++;
    if ({if_valid, if_instr, if_pc, if_pc_plus4, fault, fault_pc, inst_Addr} !== '0)
      $display("FAIL async_reset: valid=%b instr=%h pc=%h pc4=%h fault=%b fpc=%h addr=%h want all 0",
               if_valid, if_instr, if_pc, if_pc_plus4, fault, fault_pc, inst_Addr);
    else pass_cnt++;
`ifdef FETCH_PERF_EN
    total_cnt++;
    if ({fetch_count, stall_count} !== '0)
      $display("FAIL async_reset_counters: fetch=%0d stall=%0d want 0/0", fetch_count, stall_count);
    else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    bit          rv, rdy;
    for (int ep = 0; ep < 8; ep++) begin
      for (int k = 0; k < 8; k++) mem[k] = $urandom;
      do_reset(1'b0);
      for (int c = 0; c < 60; c++) begin
        rv  = ($urandom_range(0, 9) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 19))
          0:       tgt = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
          1:       tgt = 32'h20 + 32'($urandom_range(0, 15) * 4);
          default: tgt = 32'($urandom_range(0, 7) * 4);
        endcase
        @(negedge clk);
        if (if_valid && rdy) begin
          total_cnt++;
          if (if_instr !== mem[if_pc[4:2]] || if_pc_plus4 !== if_pc + 32'd4 || if_pc[1:0] !== 2'b00)
            $display("FAIL rand_transfer: pc=%h instr=%h pc4=%h want instr=%h pc4=%h",
                     if_pc, if_instr, if_pc_plus4, mem[if_pc[4:2]], if_pc + 32'd4);
          else pass_cnt++;
        end
        redirect_valid = rv; redirect_target = tgt; if_ready = rdy;
        model_step(rv, tgt, rdy);
        @(posedge clk);
        #1;
        total_cnt++;
        if ({inst_Addr, if_valid, fault, fault_pc} !== {m_pc, m_valid, m_fault, m_fault_pc} ||
            (m_valid && {if_instr, if_pc, if_pc_plus4} !== {m_instr, m_ifpc, m_ifpc4}))
          $display("FAIL rand_ep%0d_c%0d: addr=%h valid=%b instr=%h pc=%h fault=%b fpc=%h want addr=%h valid=%b instr=%h pc=%h fault=%b fpc=%h",
                   ep, c, inst_Addr, if_valid, if_instr, if_pc, fault, fault_pc,
                   m_pc, m_valid, m_instr, m_ifpc, m_fault, m_fault_pc);
        else pass_cnt++;
`ifdef FETCH_PERF_EN
        total_cnt++;
        if ({fetch_count, stall_count} !== {m_fetch, m_stall})
          $display("FAIL rand_counters: fetch=%0d stall=%0d want %0d/%0d", fetch_count, stall_count, m_fetch, m_stall);
        else pass_cnt++;
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_range();
    test_async_reset();
    load_fixed_mem();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
